// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the M-stage load/store port.
// A request is latched, WAIT_CYCLES wait states are inserted, and then the
// word array is read (old value) and byte-written in a single access edge.
// A one-cycle data_ok pulse follows. stall holds the pipeline meanwhile.
//
// Optional feature: define DMEM_ERR_EN to enable access checking
// (out-of-range address, illegal byte-enable pattern, misalignment).
// When it is undefined, err stays 0 and high address bits alias.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req_en     request valid, held with req_* stable until data_ok
//   req_wen    byte write enables, 0000 = load
//   req_addr   byte address
//   req_wdata  lane-replicated store data
//   rdata      registered read data (word before any write of the access)
//   data_ok    registered one-cycle completion pulse
//   stall      combinational req_en & ~data_ok
//   err        registered access error, coincident with data_ok
module dmem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic [3:0]  req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        data_ok,
    output logic        stall,
    output logic        err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         wen_q, wen_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               req_err_q, req_err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               data_ok_q, data_ok_d;
    logic               err_q, err_d;

    logic [31:0]        mem [DEPTH];

    logic               acc_fire;
    logic [3:0]         acc_wen;
    logic [ADDR_W-1:0]  acc_idx;
    logic [31:0]        acc_wdata;
    logic               acc_err;

    logic [ADDR_W-1:0]  req_idx;
    logic               req_err_c;
    logic               unused_addr;

    assign req_idx     = req_addr[ADDR_W+1:2];
    assign unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

`ifdef DMEM_ERR_EN
    // Request legality, evaluated on the live inputs at latch time.
    always_comb begin
        req_err_c = 1'b0;
        if ((req_addr >> (ADDR_W + 2)) != 32'd0) begin
            req_err_c = 1'b1;
        end
        case (req_wen)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: ;
            4'b0011, 4'b1100: begin
                if (req_addr[0]) begin
                    req_err_c = 1'b1;
                end
            end
            4'b1111: begin
                if (req_addr[1:0] != 2'b00) begin
                    req_err_c = 1'b1;
                end
            end
            default: req_err_c = 1'b1;
        endcase
    end
`else
    assign req_err_c = 1'b0;
`endif

    // Next-state, request latch and access control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wen_d     = wen_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        req_err_d = req_err_q;
        rdata_d   = rdata_q;
        data_ok_d = 1'b0;
        err_d     = 1'b0;
        acc_fire  = 1'b0;
        acc_wen   = wen_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        acc_err   = req_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_en) begin
                    wen_d     = req_wen;
                    idx_d     = req_idx;
                    wdata_d   = req_wdata;
                    req_err_d = req_err_c;
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: access uses the live request on the latch edge.
                        acc_fire  = 1'b1;
                        acc_wen   = req_wen;
                        acc_idx   = req_idx;
                        acc_wdata = req_wdata;
                        acc_err   = req_err_c;
                        state_d   = ST_RESP;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    acc_fire = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                // The still-held completing request must not be re-accepted here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (acc_fire) begin
            data_ok_d = 1'b1;
            err_d     = acc_err;
            if (!acc_err) begin
                rdata_d = mem[acc_idx];
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wen_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            req_err_q <= 1'b0;
            rdata_q   <= '0;
            data_ok_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wen_q     <= wen_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            req_err_q <= req_err_d;
            rdata_q   <= rdata_d;
            data_ok_q <= data_ok_d;
            err_q     <= err_d;
        end
    end

    // Word array, not reset; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst && acc_fire && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wen[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata   = rdata_q;
    assign data_ok = data_ok_q;
    assign err     = err_q;
    assign stall   = req_en & ~data_ok_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: two instances (WAIT_CYCLES=0 and 2) checked
// against a word-array reference model using randomized and directed accesses.
module tb_dmem_responder;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_en;
    logic [7:0]  req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] rdata;
    logic [1:0]  data_ok;
    logic [1:0]  stall;
    logic [1:0]  err;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_en    (req_en[0]),
        .req_wen   (req_wen[3:0]),
        .req_addr  (req_addr[31:0]),
        .req_wdata (req_wdata[31:0]),
        .rdata     (rdata[31:0]),
        .data_ok   (data_ok[0]),
        .stall     (stall[0]),
        .err       (err[0])
    );

    dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .req_en    (req_en[1]),
        .req_wen   (req_wen[7:4]),
        .req_addr  (req_addr[63:32]),
        .req_wdata (req_wdata[63:32]),
        .rdata     (rdata[63:32]),
        .data_ok   (data_ok[1]),
        .stall     (stall[1]),
        .err       (err[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per-instance word array with known-value flags.
    logic [31:0] mem_m [2][DEPTH];
    bit          vld_m [2][DEPTH];
    logic [31:0] rd_m  [2];
    bit          rd_vld[2];

    function automatic int wc(input int sel);
        return (sel == 0) ? 0 : 2;
    endfunction

    function automatic bit exp_err(input logic [3:0] wen, input logic [31:0] addr);
`ifdef DMEM_ERR_EN
        bit legal;
        legal = wen inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
        if ((addr >> (AW + 2)) != 32'd0) return 1'b1;
        if (!legal) return 1'b1;
        if ((wen == 4'h3 || wen == 4'hC) && addr[0]) return 1'b1;
        if (wen == 4'hF && addr[1:0] != 2'b00) return 1'b1;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic go_idle(input int sel);
        @(posedge clk); #1;
        req_en[sel] = 1'b0;
    endtask

    // One full request/response on instance sel, with per-cycle timing checks.
    task automatic do_access(input int sel, input logic [3:0] wen, input logic [31:0] addr,
                             input logic [31:0] wdata, input string tag,
                             output logic [31:0] rd_o, output logic er_o);
        int          idx;
        int          lat;
        int          exp_lat;
        logic [31:0] rd_exp;
        logic [31:0] nw;
        bit          rd_known;
        bit          er_exp;
        idx     = int'((addr >> 2) % DEPTH);
        exp_lat = 1 + wc(sel);
        er_exp  = exp_err(wen, addr);
        if (er_exp) begin
            rd_exp   = rd_m[sel];
            rd_known = rd_vld[sel];
        end else begin
            rd_exp   = mem_m[sel][idx];
            rd_known = vld_m[sel][idx];
        end
        rd_o = '0;
        er_o = 1'b0;
        @(posedge clk); #1;
        req_en[sel]             = 1'b1;
        req_wen[sel*4 +: 4]     = wen;
        req_addr[sel*32 +: 32]  = addr;
        req_wdata[sel*32 +: 32] = wdata;
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c <= exp_lat) begin
                n_checks++;
                if (data_ok[sel] !== 1'(c == exp_lat)) begin
                    n_fail++;
                    $display("FAIL %s data_ok cycle %0d: got %b want %b", tag, c, data_ok[sel], (c == exp_lat));
                end
                n_checks++;
                if (stall[sel] !== 1'(c != exp_lat)) begin
                    n_fail++;
                    $display("FAIL %s stall cycle %0d: got %b want %b", tag, c, stall[sel], (c != exp_lat));
                end
            end
            if (data_ok[sel] === 1'b1) begin
                lat = c;
                break;
            end
        end
        n_checks++;
        if (lat < 0) begin
            n_fail++;
            $display("FAIL %s timeout: no data_ok within 40 cycles, want latency %0d", tag, exp_lat);
        end else begin
            rd_o = rdata[sel*32 +: 32];
            er_o = err[sel];
            if (rd_known) begin
                n_checks++;
                if (rd_o !== rd_exp) begin
                    n_fail++;
                    $display("FAIL %s rdata: got %h want %h", tag, rd_o, rd_exp);
                end
            end
            n_checks++;
            if (er_o !== er_exp) begin
                n_fail++;
                $display("FAIL %s err: got %b want %b", tag, er_o, er_exp);
            end
        end
        if (!er_exp) begin
            nw = mem_m[sel][idx];
            for (int b = 0; b < 4; b++) begin
                if (wen[b]) nw[8*b +: 8] = wdata[8*b +: 8];
            end
            mem_m[sel][idx] = nw;
            if (wen == 4'hF) vld_m[sel][idx] = 1'b1;
        end
        rd_m[sel]   = rd_exp;
        rd_vld[sel] = rd_known;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_en    = '0;
        req_wen   = '0;
        req_addr  = '0;
        req_wdata = '0;
        #3;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if (rdata[s*32 +: 32] !== 32'h0 || data_ok[s] !== 1'b0 || err[s] !== 1'b0 || stall[s] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset inst%0d: rdata=%h data_ok=%b err=%b stall=%b want 0/0/0/0",
                         s, rdata[s*32 +: 32], data_ok[s], err[s], stall[s]);
            end
            rd_m[s]   = '0;
            rd_vld[s] = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_fill();
        logic [31:0] r;
        logic        e;
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++) begin
                do_access(s, 4'hF, 32'(w * 4), $urandom, "fill", r, e);
            end
            go_idle(s);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] r;
        logic        e;
        do_access(1, 4'hF, 32'h10, 32'h1234_5678, "store_full", r, e);
        go_idle(1);
        do_access(1, 4'h0, 32'h10, $urandom, "load_full", r, e);
        n_checks++;
        if (r !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL load_full_const: got %h want 12345678", r);
        end
        go_idle(1);
        do_access(1, 4'b0100, 32'h12, 32'hABAB_ABAB, "store_byte2", r, e);
        go_idle(1);
        do_access(1, 4'h0, 32'h10, $urandom, "load_byte2", r, e);
        n_checks++;
        if (r !== 32'h12AB_5678) begin
            n_fail++;
            $display("FAIL load_byte2_const: got %h want 12ab5678", r);
        end
        go_idle(1);
    endtask

    // Zero wait states, requester holds req_en across two loads.
    task automatic test_back_to_back();
        logic [31:0] r;
        logic        e;
        go_idle(0);
        do_access(0, 4'h0, 32'h10, $urandom, "b2b_first", r, e);
        do_access(0, 4'h0, 32'h14, $urandom, "b2b_second", r, e);
        go_idle(0);
    endtask

    task automatic test_alias();
`ifndef DMEM_ERR_EN
        logic [31:0] r1;
        logic [31:0] r2;
        logic        e;
        do_access(1, 4'h0, 32'h10, $urandom, "alias_base", r1, e);
        go_idle(1);
        do_access(1, 4'h0, 32'h10 + (32'd4 << AW), $urandom, "alias_high", r2, e);
        go_idle(1);
        n_checks++;
        if (r2 !== 32'h12AB_5678 || r1 !== 32'h12AB_5678) begin
            n_fail++;
            $display("FAIL alias: got %h / %h want 12ab5678 for both", r1, r2);
        end
`endif
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] r;
        logic        e;
        @(posedge clk); #1;
        req_en[1]        = 1'b1;
        req_wen[7:4]     = 4'hF;
        req_addr[63:32]  = 32'h20;
        req_wdata[63:32] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        rst       = 1'b0;
        req_en[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (data_ok[1] !== 1'b0 || rdata[63:32] !== 32'h0 || err[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_wait cycle %0d: data_ok=%b rdata=%h err=%b want 0/0/0",
                         c, data_ok[1], rdata[63:32], err[1]);
            end
        end
        rd_m[0] = '0; rd_vld[0] = 1'b1;
        rd_m[1] = '0; rd_vld[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (data_ok[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_wait_after cycle %0d: data_ok got %b want 0", c, data_ok[1]);
            end
        end
        do_access(1, 4'h0, 32'h20, $urandom, "rst_wait_load", r, e);
        go_idle(1);
    endtask

    task automatic test_err();
`ifdef DMEM_ERR_EN
        logic [31:0] r;
        logic        e;
        do_access(1, 4'hF, 32'h22, 32'hDEAD_BEEF, "err_misalign", r, e);
        n_checks++;
        if (e !== 1'b1) begin
            n_fail++;
            $display("FAIL err_misalign_const: got %b want 1", e);
        end
        go_idle(1);
        do_access(1, 4'h0, 32'h20, $urandom, "err_unchanged", r, e);
        go_idle(1);
        do_access(1, 4'h0, 32'h8000_0000, $urandom, "err_range", r, e);
        n_checks++;
        if (e !== 1'b1) begin
            n_fail++;
            $display("FAIL err_range_const: got %b want 1", e);
        end
        go_idle(1);
`endif
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic        e;
        logic [31:0] addr;
        int          s;
        for (int n = 0; n < 60; n++) begin
            s    = int'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) addr = addr | (32'($urandom_range(1, 7)) << (AW + 2));
            do_access(s, 4'($urandom_range(0, 15)), addr, $urandom, "random", r, e);
            go_idle(s);
        end
    endtask

    task automatic test_hold();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            if (rd_vld[s]) begin
                n_checks++;
                if (rdata[s*32 +: 32] !== rd_m[s] || data_ok[s] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold inst%0d: rdata=%h data_ok=%b want %h/0",
                             s, rdata[s*32 +: 32], data_ok[s], rd_m[s]);
                end
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < int'(DEPTH); w++) begin
                mem_m[s][w] = '0;
                vld_m[s][w] = 1'b0;
            end
        end
        test_reset();
        test_fill();
        test_store_load();
        test_back_to_back();
        test_alias();
        test_reset_in_wait();
        test_err();
        test_random();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the datapath's M-stage load/store interface.
- Accepts a request (byte write enables, byte address, write data), inserts a fixed number of wait states, then performs the word-array access.
- Returns read data with a one-cycle `data_ok` pulse.
- Drives `stall` to the hazard unit so the pipeline holds while the access is outstanding.

Parameters:
- ADDR_W, 10, word-address width; array depth = 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2, wait states inserted before the access edge (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_en  in  1  request valid; held high, with all req_* signals stable, until `data_ok`.
- req_wen  in  4  byte write enables (lane i = bits 8i+7:8i); 0000 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, already lane-replicated by the requester.
- rdata  out  32  read data (word before any write in the same access).
- data_ok  out  1  one-cycle completion pulse.
- stall  out  1  combinational: req_en & ~data_ok.
- err  out  1  access error; see Optional Feature.

Behaviour:
- Reset (rst low, async):
  - state=IDLE, cnt=0, rdata=0, data_ok=0, err=0.
  - Latched request registers cleared.
  - Array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with req_en=1, latch wen, word index addr[ADDR_W+1:2] and wdata.
  - If WAIT_CYCLES=0: perform the access on this same edge and go to RESP.
  - Else: cnt<=WAIT_CYCLES and go to WAIT.
- WAIT:
  - cnt decrements each edge.
  - On the edge where cnt==1: perform the access and go to RESP.
  - req_en/inputs are ignored in WAIT; the latched copy is used.
- Access edge:
  - rdata <= mem[idx], the old value.
  - For each i with wen[i]=1: mem[idx] byte i <= wdata byte i.
- RESP:
  - data_ok=1 for exactly this cycle.
  - Unconditional transition to IDLE.
  - req_en seen during RESP is not accepted, since it is the completing request still held; a new request is accepted from IDLE on the following cycle.
- Latency: request first seen in cycle 0 → data_ok in cycle 1+WAIT_CYCLES; throughput is one access per 2+WAIT_CYCLES cycles.
- rdata holds its value between accesses; a store also updates rdata with the pre-write word.
- Address: bits [1:0] are ignored; bits above ADDR_W+1 are ignored when the feature is off, so the array aliases/wraps.
- req_en dropping while in WAIT: the access still completes; data_ok still pulses.
- Reset asserted in WAIT, before the access edge: no array write occurs; returns to IDLE.
- stall is combinational, so it is high in the first request cycle with zero-cycle delay.

Optional Feature:
Macro DMEM_ERR_EN.
- Defined:
  - A request is an error if req_addr[31:ADDR_W+2] != 0, or if req_wen is not one of 0000/0001/0010/0100/1000/0011/1100/1111, or if wen=0011/1100 with addr[0]=1, or if wen=1111 with addr[1:0]!=0.
  - The error is evaluated at latch time.
  - On the access edge of an error request: array write suppressed, rdata unchanged, err=1 coincident with the data_ok pulse.
- Not defined: err tied to 0; no checking; aliasing as above.

Test Plan:
1. Reset, WAIT_CYCLES=2: store wen=1111, addr=0x10, wdata=0x12345678 → stall high cycles 0-2, data_ok in cycle 3. Then load addr=0x10 → rdata=0x12345678.
2. Store wen=0100, addr=0x12, wdata=0xABABABAB over word 0x12345678 → subsequent load returns 0x12AB5678.
3. WAIT_CYCLES=0 build: request cycle 0 → data_ok cycle 1. Two back-to-back loads held by the requester → data_ok in cycles 1 and 3, never in consecutive cycles.
4. Load at addr=0x10 and addr=0x10+(4<<ADDR_W) → both return the same word (aliasing, feature off).
5. Store 0xFFFFFFFF to addr=0x20, WAIT_CYCLES=2; pull rst low in cycle 1 → no data_ok, outputs 0; post-reset load of 0x20 returns the prior contents.
6. DMEM_ERR_EN: store wen=1111, addr=0x22 → err=1 with data_ok, word unchanged. Load addr=0x8000_0000 → err=1.
